// File: rtl/shared_acc_if.sv
// Request/grant bundle between requesters and the shared accumulator.
// Requesters drive req/data/acc_clr; the arbiter drives the rest.
interface shared_acc_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic                   acc_clr;
  logic [N_REQ-1:0]       grant;
  logic [WIDTH-1:0]       acc_out;
  logic                   ovf;
  logic                   busy;

  modport master (
    output req, data, acc_clr,
    input  grant, acc_out, ovf, busy
  );

  modport slave (
    input  req, data, acc_clr,
    output grant, acc_out, ovf, busy
  );
endinterface

// File: rtl/shared_acc_arbiter.sv
// Round-robin arbiter feeding one saturating accumulator.
// Each transaction walks IDLE -> GRANT -> UPDATE.
module shared_acc_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         rst,
  shared_acc_if.slave bus
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    UPDATE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             found;
  logic [PW-1:0]    pick;
  logic [PW-1:0]    cand;
  logic [WIDTH-1:0] sel;
  logic [WIDTH:0]   sum;

  // Search upward from the last winner so it gets lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % N_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_q == PW'(i)) begin
        sel = bus.data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum = {1'b0, acc_q} + {1'b0, opnd_q};

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        opnd_d  = sel;
        state_d = UPDATE;
      end
      UPDATE: begin
        ptr_d   = win_q;
        state_d = IDLE;
        if (sum[WIDTH]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[WIDTH-1:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Clear wins over a same-cycle update.
    if (bus.acc_clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      win_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.acc_out = acc_q;
  assign bus.ovf     = ovf_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_shared_acc_arbiter.sv
// Scoreboard bench for shared_acc_arbiter (N_REQ=4, WIDTH=4).
module tb_shared_acc_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shared_acc_if #(.N_REQ(N), .WIDTH(W)) bus ();

  shared_acc_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [N-1:0] g;
    logic [W-1:0] acc;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr;
  int   m_acc;
  bit   m_ovf;

  function automatic int rr(input logic [N-1:0] r, input int p);
    for (int i = 1; i <= N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] pack(
    input int d0, input int d1, input int d2, input int d3);
    logic [N*W-1:0] v;
    v = {W'(d3), W'(d2), W'(d1), W'(d0)};
    return v;
  endfunction

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    bus.acc_clr = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = N - 1;
    m_acc = 0;
    m_ovf = 1'b0;
  endtask

  // One full transaction: predict, push, then check each phase.
  task automatic txn(input logic [N-1:0] r, input logic [N*W-1:0] d,
                     input bit clr, input bit keep, input string nm);
    exp_t e;
    int   w;
    int   dv;
    @(negedge clk);
    bus.req  = r;
    bus.data = d;
    w = rr(r, m_ptr);
    e.g = '0;
    e.g[w] = 1'b1;
    dv = int'(d[w*W +: W]);
    if (clr) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end else begin
      m_acc = m_acc + dv;
      if (m_acc > (1 << W) - 1) begin
        m_acc = (1 << W) - 1;
        m_ovf = 1'b1;
      end
    end
    m_ptr = w;
    e.acc = W'(m_acc);
    e.ovf = m_ovf;
    sb.push_back(e);

    @(posedge clk);
    #1;
    checks++;
    if (bus.grant !== sb[0].g) begin
      errors++;
      $display("FAIL %s grant got %b want %b", nm, bus.grant, sb[0].g);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_grant got %b want 1", nm, bus.busy);
    end
    if (!keep) bus.req = '0;

    @(posedge clk);
    #1;
    checks++;
    if (bus.grant !== '0) begin
      errors++;
      $display("FAIL %s grant_upd got %b want 0", nm, bus.grant);
    end
    bus.acc_clr = clr;

    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bus.acc_out !== e.acc || bus.ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s acc/ovf got %0d/%b want %0d/%b",
               nm, bus.acc_out, bus.ovf, e.acc, e.ovf);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.grant !== '0) begin
      errors++;
      $display("FAIL %s idle got busy %b grant %b want 0/0",
               nm, bus.busy, bus.grant);
    end
  endtask

  task automatic test_reset();
    do_rst();
    checks++;
    if (bus.grant !== '0 || bus.acc_out !== '0 ||
        bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset got g%b a%0d o%b b%b want 0/0/0/0",
               bus.grant, bus.acc_out, bus.ovf, bus.busy);
    end
  endtask

  task automatic test_single();
    txn(4'b0001, pack(3, 0, 0, 0), 1'b0, 1'b0, "single");
  endtask

  task automatic test_round_robin();
    do_rst();
    for (int k = 0; k < 5; k++) begin
      txn(4'b1111, pack(1, 1, 1, 1), 1'b0, 1'b1, "rr");
    end
    bus.req = '0;
  endtask

  task automatic test_saturate();
    do_rst();
    txn(4'b0001, pack(14, 0, 0, 0), 1'b0, 1'b0, "sat_base");
    txn(4'b0010, pack(0, 5, 0, 0), 1'b0, 1'b0, "sat_ovf");
    txn(4'b0100, pack(0, 0, 0, 0), 1'b0, 1'b0, "sat_add0");
    txn(4'b1000, pack(0, 0, 0, 2), 1'b0, 1'b0, "sat_sticky");
    @(negedge clk);
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
    m_acc = 0;
    m_ovf = 1'b0;
    checks++;
    if (bus.acc_out !== '0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle got %0d/%b want 0/0", bus.acc_out, bus.ovf);
    end
  endtask

  task automatic test_clr_update();
    do_rst();
    txn(4'b0001, pack(15, 0, 0, 0), 1'b0, 1'b0, "clr_fill");
    txn(4'b0001, pack(1, 0, 0, 0), 1'b0, 1'b0, "clr_ovf");
    txn(4'b0010, pack(0, 7, 0, 0), 1'b1, 1'b0, "clr_upd");
    txn(4'b1111, pack(2, 2, 2, 2), 1'b0, 1'b0, "clr_next");
  endtask

  task automatic test_reset_in_grant();
    exp_t e;
    do_rst();
    txn(4'b0001, pack(5, 0, 0, 0), 1'b0, 1'b0, "rg_pre");
    @(negedge clk);
    bus.req = 4'b1111;
    bus.data = pack(1, 1, 1, 1);
    e.g = '0;
    e.g[rr(4'b1111, m_ptr)] = 1'b1;
    e.acc = '0;
    e.ovf = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (bus.grant !== sb[0].g) begin
      errors++;
      $display("FAIL rg_grant got %b want %b", bus.grant, sb[0].g);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 ||
        bus.acc_out !== e.acc || bus.ovf !== e.ovf) begin
      errors++;
      $display("FAIL rg_flush got g%b b%b a%0d want 0/0/0",
               bus.grant, bus.busy, bus.acc_out);
    end
    @(negedge clk);
    rst = 1'b0;
    m_ptr = N - 1;
    m_acc = 0;
    m_ovf = 1'b0;
    txn(4'b1010, pack(0, 6, 0, 9), 1'b0, 1'b0, "rg_after");
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.data = '0;
    bus.acc_clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_saturate();
    test_clr_update();
    test_reset_in_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shared_acc_arbiter.md
SHARED_ACC_ARBITER -- requirements
Module: shared_acc_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 4, SHALL set the data and accumulator width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 req  input  N_REQ  SHALL carry one request line per requester, held high until that requester's grant is seen.
REQ-006 data  input  N_REQ*WIDTH  SHALL carry the operand of requester i in bits [i*WIDTH +: WIDTH].
REQ-007 acc_clr  input  1  SHALL be a synchronous clear of acc_out and ovf.
REQ-008 grant  output  N_REQ  SHALL be a registered, one-hot, single-cycle grant.
REQ-009 acc_out  output  WIDTH  SHALL be the registered shared accumulator, the only writer of the shared resource.
REQ-010 ovf  output  1  SHALL be a registered, sticky saturation flag.
REQ-011 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have exactly three legal states: IDLE=2'b00, GRANT=2'b01, UPDATE=2'b10.
REQ-013 Encoding 2'b11 SHALL be illegal and SHALL transition to IDLE on the next edge with grant=0 and no accumulator update.
REQ-014 In IDLE with req==0, the FSM SHALL stay in IDLE.
REQ-015 In IDLE with any req bit high, the FSM SHALL pick a winner round-robin, searching upward from ptr+1 modulo N_REQ, and SHALL move to GRANT.
REQ-016 ptr SHALL hold the index of the last granted requester.
REQ-017 During GRANT, grant SHALL be the one-hot winner for exactly one cycle, and the winner's data SHALL be captured into an internal operand register.
REQ-018 A winner dropping req during GRANT SHALL NOT cancel the transaction; the operand is still captured.
REQ-019 GRANT SHALL always go to UPDATE on the next edge.
REQ-020 In UPDATE, acc_out SHALL be updated to min(acc_out + operand, 2^WIDTH-1), computed at WIDTH+1 bits; any carry out SHALL set ovf.
REQ-021 In UPDATE, ptr SHALL be updated to the winner index, and the FSM SHALL return to IDLE.
REQ-022 ovf SHALL stay set until rst or acc_clr.
REQ-023 Latency: req sampled at edge k means grant is high between edges k and k+1, and acc_out is updated at edge k+2.
REQ-024 Throughput SHALL be one transaction per 3 cycles.
REQ-025 acc_clr SHALL zero acc_out and ovf at the next edge in any state, and SHALL take priority over an UPDATE in the same cycle.
REQ-026 When acc_clr coincides with UPDATE, the operand SHALL be dropped, ptr SHALL still advance, and the FSM SHALL still return to IDLE.
REQ-027 grant SHALL be all-zero in every state other than GRANT.
REQ-028 grant SHALL never have more than one bit set.
REQ-029 Each signal SHALL be driven from exactly one always block.
REQ-030 No latches SHALL be inferred, and every case statement SHALL have a default branch.

Reset
REQ-031 When rst is high at an edge, the block SHALL load state=IDLE, grant=0, acc_out=0, ovf=0, busy=0 and ptr=N_REQ-1, so requester 0 has first priority.
REQ-032 rst SHALL override acc_clr and any in-flight transaction, which SHALL be discarded.

Verification (N_REQ=4, WIDTH=4)
REQ-033 After reset, req=0001 and data0=3 -> grant=0001 for one cycle, then acc_out=3, ovf=0, busy=0.
REQ-034 req=1111 held, all data=1 -> grants 0001, 0010, 0100, 1000, 0001 spaced 3 cycles apart; acc_out counts 1, 2, 3, 4, 5.
REQ-035 acc_out=14 and winner data=5 -> acc_out=15 and ovf=1; a following add of 0 -> acc_out=15, ovf=1.
REQ-036 acc_clr high during UPDATE with last winner 1 -> acc_out=0, ovf=0, and the next grant with req=1111 is 0100.
REQ-037 rst high during GRANT -> at the next edge grant=0, busy=0, acc_out=0; with req=1010 the next grant is 0010.
